// File: rtl/alu_core.sv
// Execute-stage integer ALU: one registered result per clock with Zero and
// signed LesserThan flags captured alongside it.
module alu_core #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       ALUControl,
    output logic             Zero,
    output logic             LesserThan,
    output logic [WIDTH-1:0] ALUOut
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHAMT_W-1:0]      shamt;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic [WIDTH-1:0]        sra_res;
    logic                    lt_s;
    logic                    lt_u;

    logic [WIDTH-1:0]        result_d;
    logic                    zero_d;
    logic [WIDTH-1:0]        out_q;
    logic                    zero_q;
    logic                    lt_q;

    assign a_s     = srcA;
    assign b_s     = srcB;
    // Only the low SHAMT_W bits steer shifts; shift by 33 behaves as shift by 1.
    assign shamt   = srcB[SHAMT_W-1:0];
    assign sum     = srcA + srcB;
    assign diff    = srcA - srcB;
    assign sra_res = a_s >>> shamt;
    assign lt_s    = a_s < b_s;
    assign lt_u    = srcA < srcB;

    always_comb begin
        result_d = '0;
        case (ALUControl)
            OP_ADD:  result_d = sum;
            OP_SUB:  result_d = diff;
            OP_AND:  result_d = srcA & srcB;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_OR:   result_d = srcA | srcB;
            OP_XOR:  result_d = srcA ^ srcB;
            OP_SLL:  result_d = srcA << shamt;
            OP_SRL:  result_d = srcA >> shamt;
            OP_SRA:  result_d = sra_res;
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_u};
            default: result_d = '0;
        endcase
    end

    // Zero comes from the same value being registered, so flag and result never disagree.
    assign zero_d = (result_d == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            zero_q <= 1'b1;
            lt_q   <= 1'b0;
        end else begin
            out_q  <= result_d;
            zero_q <= zero_d;
            lt_q   <= lt_s;
        end
    end

    assign ALUOut     = out_q;
    assign Zero       = zero_q;
    assign LesserThan = lt_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed and back-to-back stimulus for alu_core, checked every cycle against
// an arithmetic reference model plus hand-computed literal results.
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  ALUControl;
    logic        Zero;
    logic        LesserThan;
    logic [31:0] ALUOut;

    alu_core #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .srcA       (srcA),
        .srcB       (srcB),
        .ALUControl (ALUControl),
        .Zero       (Zero),
        .LesserThan (LesserThan),
        .ALUOut     (ALUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        z;
        logic        lt;
    } vec_t;

    typedef struct packed {
        logic        has;
        logic [31:0] out;
        logic        z;
        logic        lt;
    } lit_t;

    vec_t vecs [25];
    lit_t cur_lit;

    logic [31:0] exp_out;
    logic        exp_z;
    logic        exp_lt;
    lit_t        exp_lit;
    logic        exp_valid;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] ref_out(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, p;
        int sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
        sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
        sh = int'(b[4:0]);
        p  = longint'(1) << sh;
        case (op)
            4'd0: return 32'(ua + ub);
            4'd1: return 32'(ua - ub);
            4'd2: return a & b;
            4'd3: return (sa < sb) ? 32'd1 : 32'd0;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return 32'(ua * p);
            4'd7: return 32'(ua / p);
            4'd8: return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
            4'd9: return (ua < ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = a[31] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = b[31] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        return sa < sb;
    endfunction

    // Model: what each edge must capture, from the inputs present at that edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_valid = 1'b0;
        end else begin
            exp_out   = ref_out(ALUControl, srcA, srcB);
            exp_z     = (exp_out == 32'd0);
            exp_lt    = ref_lt(srcA, srcB);
            exp_lit   = cur_lit;
            exp_valid = 1'b1;
        end
    end

    // Single compare process: every negedge, plus right after reset rises.
    initial begin
        forever begin
            @(negedge clk or posedge reset);
            #1;
            if (reset) begin
                n_vec++;
                if (ALUOut !== 32'd0 || Zero !== 1'b1 || LesserThan !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_state: got out=%h z=%b lt=%b, want out=00000000 z=1 lt=0",
                             ALUOut, Zero, LesserThan);
                end
            end else if (!clk && exp_valid) begin
                n_vec++;
                if (ALUOut !== exp_out || Zero !== exp_z || LesserThan !== exp_lt) begin
                    n_bad++;
                    $display("FAIL model t=%0t: got out=%h z=%b lt=%b, want out=%h z=%b lt=%b",
                             $time, ALUOut, Zero, LesserThan, exp_out, exp_z, exp_lt);
                end
                if (exp_lit.has) begin
                    n_vec++;
                    if (ALUOut !== exp_lit.out || Zero !== exp_lit.z || LesserThan !== exp_lit.lt) begin
                        n_bad++;
                        $display("FAIL literal t=%0t: got out=%h z=%b lt=%b, want out=%h z=%b lt=%b",
                                 $time, ALUOut, Zero, LesserThan, exp_lit.out, exp_lit.z, exp_lit.lt);
                    end
                end
            end
        end
    end

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic has, input logic [31:0] o, input logic z, input logic lt);
        @(posedge clk);
        #1;
        ALUControl = op;
        srcA       = a;
        srcB       = b;
        cur_lit    = '{has: has, out: o, z: z, lt: lt};
    endtask

    initial begin
        vecs[0]  = '{op: 4'd0,  a: 32'd6,          b: 32'd3,          out: 32'd9,          z: 1'b0, lt: 1'b0};
        vecs[1]  = '{op: 4'd1,  a: 32'd0,          b: 32'd0,          out: 32'd0,          z: 1'b1, lt: 1'b0};
        vecs[2]  = '{op: 4'd1,  a: 32'd1,          b: 32'd3,          out: 32'hFFFFFFFE,   z: 1'b0, lt: 1'b1};
        vecs[3]  = '{op: 4'd0,  a: 32'hFFFFFFFF,   b: 32'd1,          out: 32'd0,          z: 1'b1, lt: 1'b1};
        vecs[4]  = '{op: 4'd3,  a: 32'd3,          b: 32'd6,          out: 32'd1,          z: 1'b0, lt: 1'b1};
        vecs[5]  = '{op: 4'd3,  a: 32'd6,          b: 32'd6,          out: 32'd0,          z: 1'b1, lt: 1'b0};
        vecs[6]  = '{op: 4'd3,  a: 32'hFFFFFFF9,   b: 32'd1,          out: 32'd1,          z: 1'b0, lt: 1'b1};
        vecs[7]  = '{op: 4'd9,  a: 32'hFFFFFFF9,   b: 32'd1,          out: 32'd0,          z: 1'b1, lt: 1'b1};
        vecs[8]  = '{op: 4'd9,  a: 32'd24,         b: 32'd7,          out: 32'd0,          z: 1'b1, lt: 1'b0};
        vecs[9]  = '{op: 4'd2,  a: 32'd6,          b: 32'd3,          out: 32'd2,          z: 1'b0, lt: 1'b0};
        vecs[10] = '{op: 4'd4,  a: 32'd6,          b: 32'd3,          out: 32'd7,          z: 1'b0, lt: 1'b0};
        vecs[11] = '{op: 4'd5,  a: 32'd5,          b: 32'd3,          out: 32'd6,          z: 1'b0, lt: 1'b0};
        vecs[12] = '{op: 4'd5,  a: 32'd5,          b: 32'd5,          out: 32'd0,          z: 1'b1, lt: 1'b0};
        vecs[13] = '{op: 4'd6,  a: 32'd4,          b: 32'd1,          out: 32'd8,          z: 1'b0, lt: 1'b0};
        vecs[14] = '{op: 4'd6,  a: 32'd4,          b: 32'd2,          out: 32'd16,         z: 1'b0, lt: 1'b0};
        vecs[15] = '{op: 4'd7,  a: 32'd10,         b: 32'd2,          out: 32'd2,          z: 1'b0, lt: 1'b0};
        vecs[16] = '{op: 4'd7,  a: 32'hFFFFFFF9,   b: 32'd1,          out: 32'h7FFFFFFC,   z: 1'b0, lt: 1'b1};
        vecs[17] = '{op: 4'd8,  a: 32'hFFFFFFF9,   b: 32'd1,          out: 32'hFFFFFFFC,   z: 1'b0, lt: 1'b1};
        vecs[18] = '{op: 4'd6,  a: 32'd1,          b: 32'd33,         out: 32'd2,          z: 1'b0, lt: 1'b1};
        vecs[19] = '{op: 4'd12, a: 32'h1234,       b: 32'h5678,       out: 32'd0,          z: 1'b1, lt: 1'b1};
        vecs[20] = '{op: 4'd3,  a: 32'h80000000,   b: 32'h7FFFFFFF,   out: 32'd1,          z: 1'b0, lt: 1'b1};
        vecs[21] = '{op: 4'd9,  a: 32'h80000000,   b: 32'h7FFFFFFF,   out: 32'd0,          z: 1'b1, lt: 1'b1};
        vecs[22] = '{op: 4'd15, a: 32'hFFFFFFFF,   b: 32'd0,          out: 32'd0,          z: 1'b1, lt: 1'b1};
        vecs[23] = '{op: 4'd8,  a: 32'h80000000,   b: 32'd31,         out: 32'hFFFFFFFF,   z: 1'b0, lt: 1'b1};
        vecs[24] = '{op: 4'd9,  a: 32'd1,          b: 32'hFFFFFFF9,   out: 32'd1,          z: 1'b0, lt: 1'b0};

        reset      = 1'b1;
        srcA       = 32'd0;
        srcB       = 32'd0;
        ALUControl = 4'd0;
        cur_lit    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 25; i++)
            apply(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].out, vecs[i].z, vecs[i].lt);

        // Nonzero result in flight, then reset between edges with ADD 6+3 pending.
        apply(4'd4, 32'hF0, 32'h0F, 1'b1, 32'hFF, 1'b0, 1'b0);
        apply(4'd0, 32'd6, 32'd3, 1'b1, 32'd9, 1'b0, 1'b0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        // Back-to-back ops changing every cycle, including reserved codes.
        for (int i = 0; i < 40; i++)
            apply(4'($urandom_range(0, 15)), $urandom, (i % 3 == 0) ? $urandom_range(0, 40) : $urandom,
                  1'b0, 32'd0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
